// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to DMA_ADDR halts the CPU and copies one 256-byte
// page from the CPU bus into the PPU OAMDATA register, one byte per read/write pair.
module oam_dma #(
    parameter logic [15:0] DMA_ADDR    = 16'h4014,
    parameter logic [2:0]  OAMDATA_SEL = 3'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic        cpu_halt,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        ppu_cs_n,
    output logic [2:0]  ppu_reg_addr,
    output logic        ppu_we,
    output logic [7:0]  ppu_wdata,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        odd_q;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        halt_q, halt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cs_n_q, cs_n_d;
    logic        we_q, we_d;
    logic [2:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        trigger;

    assign trigger = cpu_ce & cpu_we & (cpu_addr == DMA_ADDR);

    // CPU-cycle parity; decides whether an alignment cycle is needed before the first read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            odd_q <= 1'b0;
        end else if (cpu_ce) begin
            odd_q <= ~odd_q;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        mem_addr_d = mem_addr_q;
        halt_d     = halt_q;
        busy_d     = busy_q;
        reg_addr_d = reg_addr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        cs_n_d     = 1'b1;
        we_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    page_d  = cpu_wdata;
                    idx_d   = 8'h00;
                    halt_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (cpu_ce) begin
                    mem_addr_d = {page_q, idx_q};
                    state_d    = odd_q ? S_ALIGN : S_READ;
                end
            end
            S_ALIGN: begin
                if (cpu_ce) begin
                    mem_addr_d = {page_q, idx_q};
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                if (cpu_ce) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cpu_ce) begin
                    wdata_d    = mem_rdata;
                    reg_addr_d = OAMDATA_SEL;
                    we_d       = 1'b1;
                    cs_n_d     = 1'b0;
                    if (idx_q == 8'hFF) begin
                        // Release the CPU as the last byte goes out so the halt spans exactly the copy.
                        halt_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d      = idx_q + 8'd1;
                        mem_addr_d = {page_q, idx_q + 8'd1};
                        state_d    = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            page_q     <= 8'h00;
            idx_q      <= 8'h00;
            mem_addr_q <= 16'h0000;
            halt_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            we_q       <= 1'b0;
            reg_addr_q <= 3'd0;
            wdata_q    <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            page_q     <= page_d;
            idx_q      <= idx_d;
            mem_addr_q <= mem_addr_d;
            halt_q     <= halt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cs_n_q     <= cs_n_d;
            we_q       <= we_d;
            reg_addr_q <= reg_addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Read strobe lasts only the clk carrying the READ-state cpu_ce.
    assign mem_rd       = (state_q == S_READ) & cpu_ce;
    assign mem_addr     = mem_addr_q;
    assign cpu_halt     = halt_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign ppu_cs_n     = cs_n_q;
    assign ppu_we       = we_q;
    assign ppu_reg_addr = reg_addr_q;
    assign ppu_wdata    = wdata_q;

endmodule
